// File: rtl/apb_delayer_pkg.sv
// Shared definitions for the APB latency-scaling bridge.
//   state_e       : bridge FSM states
//   DEF_WIN_*     : default address window (base inclusive, limit exclusive)
//   sat_add()     : unsigned add that clamps at 2^width-1 instead of wrapping
package apb_delayer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        WAIT
    } state_e;

    localparam logic [31:0] DEF_WIN_BASE  = 32'ha000_0000;
    localparam logic [31:0] DEF_WIN_LIMIT = 32'hc000_0000;

    // Operands are zero-extended to 64 bits by the caller; width must be < 64.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (65'd1 << width) - 65'd1;
        return (sum > max) ? max[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator with synchronous clear and add-enable.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   clear        : zero the accumulator (wins over add_en)
//   add_en       : load next_sum into the accumulator
//   inc          : increment added each enabled cycle
//   next_sum     : sat(value + inc), combinational look-ahead of the next value
module sat_accum
    import apb_delayer_pkg::*;
#(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned INC_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             add_en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] next_sum
);

    logic [CNT_W-1:0] value_q;
    logic [63:0]      sum_wide;
    logic             unused_sum_hi;

    assign sum_wide      = sat_add(64'(value_q), 64'(inc), CNT_W);
    assign next_sum      = sum_wide[CNT_W-1:0];
    // Bits above CNT_W are always zero after saturation.
    assign unused_sum_hi = ^sum_wide[63:CNT_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else if (clear) begin
            value_q <= '0;
        end else if (add_en) begin
            value_q <= next_sum;
        end
    end

endmodule

// File: rtl/apb_latency_scaler.sv
// APB latency-scaling bridge. Passes APB transfers from the upstream fabric
// (in_*) to a slow peripheral (out_*). Transfers inside [WIN_BASE, WIN_LIMIT)
// have their upstream access phase stretched to
// max(k_total, floor(k_total * ratio / 2^FRAC_BITS)); all others pass through.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   ratio               : unsigned fixed-point scale, sampled at transfer start
//   in_p*  (request in) : upstream request; in_pready/prdata/pslverr respond
//   out_p* (request out): downstream request; out_pready/prdata/pslverr respond
module apb_latency_scaler
    import apb_delayer_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  WIN_BASE  = ADDR_W'(DEF_WIN_BASE),
    parameter logic [ADDR_W-1:0]  WIN_LIMIT = ADDR_W'(DEF_WIN_LIMIT),
    parameter int unsigned        FRAC_BITS = 4,
    parameter int unsigned        RATIO_W   = 12,
    parameter int unsigned        CNT_W     = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [RATIO_W-1:0]    ratio,

    input  logic [ADDR_W-1:0]     in_paddr,
    input  logic                  in_psel,
    input  logic                  in_penable,
    input  logic [2:0]            in_pprot,
    input  logic                  in_pwrite,
    input  logic [DATA_W-1:0]     in_pwdata,
    input  logic [DATA_W/8-1:0]   in_pstrb,
    output logic                  in_pready,
    output logic [DATA_W-1:0]     in_prdata,
    output logic                  in_pslverr,

    output logic [ADDR_W-1:0]     out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic [2:0]            out_pprot,
    output logic                  out_pwrite,
    output logic [DATA_W-1:0]     out_pwdata,
    output logic [DATA_W/8-1:0]   out_pstrb,
    input  logic                  out_pready,
    input  logic [DATA_W-1:0]     out_prdata,
    input  logic                  out_pslverr
);

    state_e               state_q, state_d;
    logic [RATIO_W-1:0]   r_q, r_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    cap_data_q, cap_data_d;
    logic                 cap_err_q, cap_err_d;

    logic                 acc_clear;
    logic                 acc_add;
    logic [CNT_W-1:0]     acc_next;   // sat(acc + r_q)
    logic [CNT_W-1:0]     k_next;     // sat(k + 1)
    logic [CNT_W-1:0]     t_val;      // scaled target access length
    logic                 win_hit;

    assign win_hit = in_psel && (in_paddr >= WIN_BASE) && (in_paddr < WIN_LIMIT);
    assign t_val   = acc_next >> FRAC_BITS;

    // Scaled downstream time, in 1/2^FRAC_BITS cycle units.
    sat_accum #(
        .CNT_W (CNT_W),
        .INC_W (RATIO_W)
    ) u_acc (
        .clock    (clock),
        .reset    (reset),
        .clear    (acc_clear),
        .add_en   (acc_add),
        .inc      (r_q),
        .next_sum (acc_next)
    );

    // Downstream access cycles seen so far.
    sat_accum #(
        .CNT_W (CNT_W),
        .INC_W (1)
    ) u_k (
        .clock    (clock),
        .reset    (reset),
        .clear    (acc_clear),
        .add_en   (acc_add),
        .inc      (1'b1),
        .next_sum (k_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            r_q        <= '0;
            cnt_q      <= '0;
            cap_data_q <= '0;
            cap_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            cap_data_q <= cap_data_d;
            cap_err_q  <= cap_err_d;
        end
    end

    always_comb begin
        out_paddr   = in_paddr;
        out_psel    = in_psel;
        out_penable = in_penable;
        out_pprot   = in_pprot;
        out_pwrite  = in_pwrite;
        out_pwdata  = in_pwdata;
        out_pstrb   = in_pstrb;
        in_pready   = out_pready;
        in_prdata   = out_prdata;
        in_pslverr  = out_pslverr;

        state_d    = state_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        cap_data_d = cap_data_q;
        cap_err_d  = cap_err_q;
        acc_clear  = 1'b0;
        acc_add    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_hit) begin
                    r_d       = ratio;
                    acc_clear = 1'b1;
                    state_d   = FWD;
                end
            end

            FWD: begin
                if (!in_psel) begin
                    // Master abandoned the transfer: no response.
                    in_pready  = 1'b0;
                    cap_data_d = '0;
                    cap_err_d  = 1'b0;
                    state_d    = IDLE;
                end else if (in_penable) begin
                    acc_add = 1'b1;
                    if (out_pready) begin
                        if (t_val > k_next) begin
                            // Hold the upstream; remaining cycles counted in WAIT.
                            in_pready  = 1'b0;
                            cap_data_d = out_prdata;
                            cap_err_d  = out_pslverr;
                            cnt_d      = t_val - k_next - CNT_W'(1);
                            state_d    = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            WAIT: begin
                out_psel    = 1'b0;
                out_penable = 1'b0;
                in_prdata   = cap_data_q;
                in_pslverr  = cap_err_q;
                if (!in_psel) begin
                    in_pready  = 1'b0;
                    cap_data_d = '0;
                    cap_err_d  = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q == '0) begin
                    in_pready = 1'b1;
                    state_d   = IDLE;
                end else begin
                    in_pready = 1'b0;
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Keep both sides quiet while reset is held, even though IDLE mirrors.
        if (reset) begin
            out_psel    = 1'b0;
            out_penable = 1'b0;
            in_pready   = 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_latency_scaler.sv
module tb_apb_latency_scaler;

    typedef struct {
        int          cycles;
        int          k;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [11:0] ratio;

    logic [31:0] m_paddr;
    logic        m_psel, m_penable, m_pwrite;
    logic [2:0]  m_pprot;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;
    logic        m_pready, m_pslverr;
    logic [31:0] m_prdata;

    logic        a_in_psel, b_in_psel;
    logic        a_in_pready, b_in_pready, a_in_pslverr, b_in_pslverr;
    logic [31:0] a_in_prdata, b_in_prdata;
    logic [31:0] a_out_paddr, b_out_paddr, a_out_pwdata, b_out_pwdata;
    logic        a_out_psel, b_out_psel, a_out_penable, b_out_penable;
    logic        a_out_pwrite, b_out_pwrite;
    logic [2:0]  a_out_pprot, b_out_pprot;
    logic [3:0]  a_out_pstrb, b_out_pstrb;

    logic [31:0] s_paddr, s_pwdata, cur_rdata;
    logic        s_psel, s_penable, s_pwrite, s_pready, cur_err;
    logic [2:0]  s_pprot;
    logic [3:0]  s_pstrb;
    int          s_cnt;
    int          cur_wait;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t e_mon;
    int   cyc;
    logic late;

    // Default-width bridge and a narrow-accumulator copy for saturation.
    apb_latency_scaler u_dut (
        .clock (clk), .reset (rst), .ratio (ratio),
        .in_paddr (m_paddr), .in_psel (a_in_psel), .in_penable (m_penable),
        .in_pprot (m_pprot), .in_pwrite (m_pwrite), .in_pwdata (m_pwdata),
        .in_pstrb (m_pstrb), .in_pready (a_in_pready), .in_prdata (a_in_prdata),
        .in_pslverr (a_in_pslverr),
        .out_paddr (a_out_paddr), .out_psel (a_out_psel), .out_penable (a_out_penable),
        .out_pprot (a_out_pprot), .out_pwrite (a_out_pwrite), .out_pwdata (a_out_pwdata),
        .out_pstrb (a_out_pstrb), .out_pready (s_pready), .out_prdata (cur_rdata),
        .out_pslverr (cur_err)
    );

    apb_latency_scaler #(.CNT_W (8)) u_dut_sat (
        .clock (clk), .reset (rst), .ratio (ratio),
        .in_paddr (m_paddr), .in_psel (b_in_psel), .in_penable (m_penable),
        .in_pprot (m_pprot), .in_pwrite (m_pwrite), .in_pwdata (m_pwdata),
        .in_pstrb (m_pstrb), .in_pready (b_in_pready), .in_prdata (b_in_prdata),
        .in_pslverr (b_in_pslverr),
        .out_paddr (b_out_paddr), .out_psel (b_out_psel), .out_penable (b_out_penable),
        .out_pprot (b_out_pprot), .out_pwrite (b_out_pwrite), .out_pwdata (b_out_pwdata),
        .out_pstrb (b_out_pstrb), .out_pready (s_pready), .out_prdata (cur_rdata),
        .out_pslverr (cur_err)
    );

    assign a_in_psel  = sel ? 1'b0 : m_psel;
    assign b_in_psel  = sel ? m_psel : 1'b0;
    assign m_pready   = sel ? b_in_pready  : a_in_pready;
    assign m_prdata   = sel ? b_in_prdata  : a_in_prdata;
    assign m_pslverr  = sel ? b_in_pslverr : a_in_pslverr;
    assign s_paddr    = sel ? b_out_paddr   : a_out_paddr;
    assign s_psel     = sel ? b_out_psel    : a_out_psel;
    assign s_penable  = sel ? b_out_penable : a_out_penable;
    assign s_pwrite   = sel ? b_out_pwrite  : a_out_pwrite;
    assign s_pwdata   = sel ? b_out_pwdata  : a_out_pwdata;
    assign s_pprot    = sel ? b_out_pprot   : a_out_pprot;
    assign s_pstrb    = sel ? b_out_pstrb   : a_out_pstrb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream peripheral: ready after cur_wait wait states.
    assign s_pready = s_psel && s_penable && (s_cnt == cur_wait);
    always @(posedge clk or posedge rst) begin
        if (rst) s_cnt <= 0;
        else if (s_psel && s_penable && !s_pready) s_cnt <= s_cnt + 1;
        else s_cnt <= 0;
    end

    // Reference: upstream access length from the ratio rule with clamped accumulator.
    function automatic int model_cycles(input logic [31:0] a, input logic [11:0] r,
                                        input int k, input int cw);
        longint prod;
        longint mx;
        int     t;
        if (a < 32'ha000_0000 || a >= 32'hc000_0000) return k;
        prod = longint'(k) * longint'(r);
        mx   = (longint'(1) << cw) - 1;
        if (prod > mx) prod = mx;
        t = int'(prod >> 4);
        return (t > k) ? t : k;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (s_psel && s_penable && s_pready) begin
            checks++;
            if ({s_paddr, s_pwrite, s_pwdata, s_pstrb, s_pprot} !==
                {m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot}) begin
                errors++;
                $display("FAIL down_req got %h/%b/%h want %h/%b/%h", s_paddr, s_pwrite,
                         s_pwdata, m_paddr, m_pwrite, m_pwdata);
            end
        end
        if (rst) begin
            checks++;
            if (m_pready !== 1'b0) begin
                errors++;
                $display("FAIL rst_pready got %b want 0", m_pready);
            end
            checks++;
            if (s_psel !== 1'b0) begin
                errors++;
                $display("FAIL rst_out_psel got %b want 0", s_psel);
            end
            exp_q.delete();
            cyc  = 0;
            late = 1'b0;
        end else if (m_psel && m_penable) begin
            cyc++;
            if (exp_q.size() > 0 && cyc > exp_q[0].k && s_psel) late = 1'b1;
            if (m_pready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_pready got response want none");
                end else begin
                    e_mon = exp_q.pop_front();
                    if (cyc != e_mon.cycles) begin
                        errors++;
                        $display("FAIL latency got %0d want %0d", cyc, e_mon.cycles);
                    end
                    checks++;
                    if (m_prdata !== e_mon.rdata) begin
                        errors++;
                        $display("FAIL prdata got %h want %h", m_prdata, e_mon.rdata);
                    end
                    checks++;
                    if (m_pslverr !== e_mon.err) begin
                        errors++;
                        $display("FAIL pslverr got %b want %b", m_pslverr, e_mon.err);
                    end
                    checks++;
                    if (late !== 1'b0) begin
                        errors++;
                        $display("FAIL wait_psel got %b want 0", late);
                    end
                end
                cyc  = 0;
                late = 1'b0;
            end
        end else begin
            if (m_pready && !m_psel && exp_q.size() == 0 && cyc != 0) begin
                checks++;
                errors++;
                $display("FAIL abort_pready got 1 want 0");
            end
            cyc  = 0;
            late = 1'b0;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 with psel low.
    task automatic xfer(input logic [31:0] addr, input logic wr, input int wt,
                        input logic [11:0] rat, input logic err, input int abort_after);
        exp_t e;
        int   n;
        ratio     = rat;
        m_paddr   = addr;
        m_pwrite  = wr;
        m_pwdata  = $urandom;
        m_pstrb   = 4'($urandom);
        m_pprot   = 3'($urandom);
        m_psel    = 1'b1;
        m_penable = 1'b0;
        cur_wait  = wt;
        cur_rdata = $urandom;
        cur_err   = err;
        e.k       = wt + 1;
        e.cycles  = model_cycles(addr, rat, wt + 1, sel ? 8 : 20);
        e.rdata   = cur_rdata;
        e.err     = err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        m_penable = 1'b1;
        ratio     = 12'($urandom);  // must not affect a transfer already started
        if (abort_after > 0) begin
            repeat (abort_after) @(posedge clk);
            #1;
            void'(exp_q.pop_back());
            m_psel    = 1'b0;
            m_penable = 1'b0;
            @(posedge clk); #1;
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_pready && n < 5000);
        if (!m_pready) begin
            checks++;
            errors++;
            $display("FAIL timeout got no pready want pready within 5000");
            exp_q.delete();
        end
        @(posedge clk); #1;
        m_psel    = 1'b0;
        m_penable = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        logic [11:0] rat;
        checks = 0; errors = 0; cyc = 0; late = 1'b0;
        rst = 1'b1; sel = 1'b0; ratio = '0;
        m_paddr = '0; m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
        m_pprot = '0; m_pwdata = '0; m_pstrb = '0;
        cur_wait = 0; cur_rdata = '0; cur_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        xfer(32'ha000_0010, 1'b0, 0, 12'h080, 1'b0, 0);   // 8 cycles
        xfer(32'hb000_0000, 1'b1, 2, 12'h080, 1'b1, 0);   // 24 cycles
        xfer(32'ha000_0000, 1'b0, 2, 12'h018, 1'b0, 0);   // 4 cycles
        xfer(32'hbfff_fffc, 1'b1, 2, 12'h010, 1'b1, 0);   // 3 cycles
        xfer(32'h8000_0000, 1'b0, 2, 12'hfff, 1'b0, 0);   // passthrough
        xfer(32'hc000_0000, 1'b0, 1, 12'hfff, 1'b1, 0);   // limit is exclusive
        xfer(32'h9fff_ffff, 1'b1, 0, 12'hfff, 1'b0, 0);
        xfer(32'ha000_0004, 1'b0, 3, 12'h000, 1'b0, 0);   // ratio 0 never shortens
        xfer(32'ha000_0008, 1'b0, 3, 12'h00c, 1'b1, 0);   // ratio < 1.0

        sel = 1'b1;                                       // CNT_W = 8 instance
        xfer(32'ha000_0000, 1'b0, 1, 12'hfff, 1'b0, 0);   // clamps at 255 -> 15
        xfer(32'hb000_0000, 1'b1, 2, 12'h080, 1'b1, 0);   // 384 clamps -> 15
        xfer(32'ha100_0000, 1'b0, 1, 12'h010, 1'b0, 0);
        sel = 1'b0;

        // Reset while WAIT holds cnt=5.
        ratio = 12'h080; m_paddr = 32'ha000_0100; m_pwrite = 1'b0;
        m_psel = 1'b1; m_penable = 1'b0;
        cur_wait = 0; cur_rdata = $urandom; cur_err = 1'b0;
        exp_q.push_back('{cycles: 8, k: 1, rdata: cur_rdata, err: 1'b0});
        @(posedge clk); #1 m_penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 m_psel = 1'b0; m_penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        xfer(32'ha000_0200, 1'b0, 0, 12'h080, 1'b1, 0);

        // Master drops psel in WAIT, then in FWD.
        xfer(32'ha000_0300, 1'b0, 0, 12'h080, 1'b0, 4);
        xfer(32'ha000_0400, 1'b1, 1, 12'h020, 1'b0, 0);
        xfer(32'ha000_0500, 1'b1, 5, 12'h080, 1'b0, 2);
        xfer(32'ha000_0600, 1'b0, 2, 12'h030, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: addr = 32'ha000_0000;
                1: addr = 32'hbfff_ffff;
                2: addr = 32'hc000_0000;
                3: addr = 32'h9fff_ffff;
                4: addr = 32'ha000_0000 + ($urandom & 32'h1fff_ffff);
                default: addr = $urandom;
            endcase
            rat = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 255));
            xfer(addr, 1'($urandom), $urandom_range(0, 4), rat, 1'($urandom), 0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
